// File: rtl/mux_rr_nx1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_nx1
//  Purpose  : N-channel registered mux with valid/ready handshakes, manual
//             select or round-robin scan that skips idle channels.
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_nx1 #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [SELW:0]   C_N    = (SELW+1)'(N);
    localparam logic [SELW-1:0] C_LAST = SELW'(N - 1);

    logic [SELW-1:0] r_ptr;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_chan;
    logic            r_out_valid;

    logic            w_load;
    logic            w_sel_ok;
    logic            w_found;
    logic [SELW-1:0] w_scan_idx;
    logic [SELW:0]   w_sum;
    logic [SELW-1:0] w_idx;
    logic [SELW-1:0] w_chosen;
    logic            w_accept;

    assign w_load   = !r_out_valid || out_ready;
    assign w_sel_ok = ({1'b0, sel} < C_N);

    // Search ptr, ptr+1, ... wrapping modulo N; first valid channel wins.
    always_comb begin
        w_found    = 1'b0;
        w_scan_idx = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (SELW+1)'(k);
            if (w_sum >= C_N) begin
                w_sum = w_sum - C_N;
            end
            w_idx = w_sum[SELW-1:0];
            if (!w_found && in_valid[w_idx]) begin
                w_found    = 1'b1;
                w_scan_idx = w_idx;
            end
        end
    end

    assign w_chosen = mode ? w_scan_idx : sel;

    // Reset masks acceptance so in_ready stays low while rst is held.
    assign w_accept = !rst && w_load &&
                      (mode ? w_found : (w_sel_ok && in_valid[sel]));

    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_chosen] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_chosen*W +: W];
            r_out_chan  <= w_chosen;
            if (mode) begin
                r_ptr <= (w_chosen == C_LAST) ? '0 : w_chosen + 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
